// File: rtl/axi4lite_master.sv
// AXI4-Lite manager: runs one read or write per accepted request and reports data/status
// on a one-cycle response strobe, with a response-phase timeout against a hung subordinate.
module axi4lite_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  aclk,
   input  logic                  areset_n,
   // Every handshake (request port and all AXI channels) completes on a rising edge where
   // valid and ready are both high; a raised valid keeps its payload stable until then.
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [3:0]            req_wstrb,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [2:0]            awprot,
   output logic                  wvalid,
   input  logic                  wready,
   output logic [31:0]           wdata,
   output logic [3:0]            wstrb,
   input  logic                  bvalid,
   output logic                  bready,
   input  logic [1:0]            bresp,
   output logic                  arvalid,
   input  logic                  arready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [2:0]            arprot,
   input  logic                  rvalid,
   output logic                  rready,
   input  logic [31:0]           rdata,
   input  logic [1:0]            rresp,
   output logic [2:0]            dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_WRESP = 3'd2,
      S_READ  = 3'd3,
      S_RRESP = 3'd4,
      S_FLUSH = 3'd5
   } state_t;

   localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit            TMO_EN   = (TIMEOUT > 0);
   localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t                  state_q, state_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    arvalid_q, arvalid_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              wstrb_q, wstrb_d;
   logic                    dir_wr_q, dir_wr_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    rsp_err_q, rsp_err_d;
   logic                    rsp_timeout_q, rsp_timeout_d;
   logic [31:0]             rsp_rdata_q, rsp_rdata_d;
   logic [CW-1:0]           tmo_cnt_q, tmo_cnt_d;
   logic                    unused_resp;

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q       <= S_IDLE;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         awaddr_q      <= '0;
         araddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         dir_wr_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         rsp_rdata_q   <= '0;
         tmo_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         arvalid_q     <= arvalid_d;
         awaddr_q      <= awaddr_d;
         araddr_q      <= araddr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         dir_wr_q      <= dir_wr_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         rsp_rdata_q   <= rsp_rdata_d;
         tmo_cnt_q     <= tmo_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      arvalid_d     = arvalid_q;
      awaddr_d      = awaddr_q;
      araddr_d      = araddr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      dir_wr_d      = dir_wr_q;
      rsp_valid_d   = 1'b0;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      tmo_cnt_d     = tmo_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               dir_wr_d = req_write;
               if (req_write) begin
                  awaddr_d  = req_addr;
                  wdata_d   = req_wdata;
                  wstrb_d   = req_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = S_WRITE;
               end else begin
                  araddr_d  = req_addr;
                  arvalid_d = 1'b1;
                  state_d   = S_READ;
               end
            end
         end
         S_WRITE: begin
            // AW and W retire independently; leave once neither is still pending.
            awvalid_d = awvalid_q & ~awready;
            wvalid_d  = wvalid_q & ~wready;
            if (!awvalid_d && !wvalid_d) begin
               state_d   = S_WRESP;
               tmo_cnt_d = '0;
            end
         end
         S_WRESP: begin
            if (bvalid) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = bresp[1];
               state_d     = S_IDLE;
            end else if (TMO_EN && tmo_cnt_q == TMO_LAST) begin
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               state_d       = S_FLUSH;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
         end
         S_READ: begin
            arvalid_d = arvalid_q & ~arready;
            if (!arvalid_d) begin
               state_d   = S_RRESP;
               tmo_cnt_d = '0;
            end
         end
         S_RRESP: begin
            if (rvalid) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = rresp[1];
               rsp_rdata_d = rdata;
               state_d     = S_IDLE;
            end else if (TMO_EN && tmo_cnt_q == TMO_LAST) begin
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               state_d       = S_FLUSH;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
         end
         S_FLUSH: begin
            // The late response has already been reported as a timeout; swallow it silently.
            if (dir_wr_q ? bvalid : rvalid) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready   = areset_n & (state_q == S_IDLE);
   assign awvalid     = awvalid_q;
   assign awaddr      = awaddr_q;
   assign awprot      = 3'b000;
   assign wvalid      = wvalid_q;
   assign wdata       = wdata_q;
   assign wstrb       = wstrb_q;
   assign bready      = (state_q == S_WRESP) | ((state_q == S_FLUSH) & dir_wr_q);
   assign arvalid     = arvalid_q;
   assign araddr      = araddr_q;
   assign arprot      = 3'b000;
   assign rready      = (state_q == S_RRESP) | ((state_q == S_FLUSH) & ~dir_wr_q);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign dbg_state_o = state_q;
   assign unused_resp = bresp[0] ^ rresp[0];

endmodule

// File: tb/tb_axi4lite_master.sv
// Bench for axi4lite_master: a cycle-stepped subordinate with programmable ready/response
// delays, and a spec-level model predicting each response, ready count and valid duration.
module tb_axi4lite_master;

   localparam int AW  = 32;
   localparam int TMO = 8;

   logic          aclk = 1'b0;
   logic          areset_n;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic [3:0]    req_wstrb;
   logic          rsp_valid, rsp_err, rsp_timeout;
   logic [31:0]   rsp_rdata;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot, dbg_state;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;

   axi4lite_master #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
      .aclk(aclk), .areset_n(areset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .dbg_state_o(dbg_state)
   );

   // clock / reset
   always #5 aclk = ~aclk;

   int          errors = 0;
   int          checks = 0;
   logic [33:0] exp_q[$];          // {timeout, err, rdata}
   logic [31:0] last_rdata = '0;
   int          exp_rdy, exp_aw, exp_w, exp_ar;
   int          o_n_rsp, o_rdy, o_viol, o_aw, o_w, o_ar;
   logic        o_err, o_tmo, o_hung;
   logic [31:0] o_rdata;

   // Reference: a response arrives after resp_dly+1 ready cycles unless that exceeds TMO.
   function automatic void predict(input logic is_wr, input int aw_dly, input int w_dly,
                                   input int ar_dly, input int resp_dly,
                                   input logic [1:0] resp, input logic [31:0] rd);
      logic tmo;
      tmo = (resp_dly >= TMO);
      if (!is_wr && !tmo) last_rdata = rd;
      exp_q.push_back({tmo, tmo | resp[1], last_rdata});
      exp_rdy = tmo ? TMO : resp_dly + 1;
      exp_aw  = is_wr ? aw_dly + 1 : 0;
      exp_w   = is_wr ? w_dly + 1 : 0;
      exp_ar  = is_wr ? 0 : ar_dly + 1;
   endfunction

   // driver + subordinate: issue one command and play the AXI side cycle by cycle
   task automatic run_txn(input logic is_wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int aw_dly, input int w_dly,
                          input int ar_dly, input int resp_dly, input logic [1:0] resp,
                          input logic [31:0] rd, input logic busy);
      int   aw_wait, w_wait, ar_wait, rs_wait;
      logic aw_pend, w_pend, ar_pend, rs_pend;
      logic aw_done, w_done, ar_done, rs_done, rsp_seen, finished;
      logic rdy_now;
      aw_wait = 0; w_wait = 0; ar_wait = 0; rs_wait = 0;
      aw_pend = 0; w_pend = 0; ar_pend = 0; rs_pend = 0;
      aw_done = 0; w_done = 0; ar_done = 0; rs_done = 0; rsp_seen = 0; finished = 0;
      o_n_rsp = 0; o_rdy = 0; o_viol = 0; o_aw = 0; o_w = 0; o_ar = 0;
      o_err = 0; o_tmo = 0; o_rdata = '0; o_hung = 0;
      @(negedge aclk);
      if (req_ready !== 1'b1) o_viol++;
      req_valid = 1; req_write = is_wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
      @(negedge aclk);
      req_valid = 0; req_addr = $urandom(); req_wdata = $urandom(); req_wstrb = 4'($urandom());
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         if (cyc == 0) begin
            if (is_wr ? !(awvalid && wvalid) : !arvalid) o_viol++;
            if (busy) begin req_valid = 1; req_write = ~is_wr; req_addr = ~addr; end
         end else begin
            req_valid = 0;
         end
         // AW channel
         if (aw_pend) begin aw_done = 1; aw_pend = 0; if (awvalid) o_viol++; end
         else if (o_aw != 0 && !aw_done && !awvalid) o_viol++;
         awready = 0;
         if (awvalid) begin
            o_aw++;
            if (!is_wr || aw_done || awaddr !== addr || awprot !== 3'b000) o_viol++;
            aw_wait++;
            if (aw_wait > aw_dly) begin awready = 1; aw_pend = 1; end
         end
         // W channel
         if (w_pend) begin w_done = 1; w_pend = 0; if (wvalid) o_viol++; end
         else if (o_w != 0 && !w_done && !wvalid) o_viol++;
         wready = 0;
         if (wvalid) begin
            o_w++;
            if (!is_wr || w_done || wdata !== wd || wstrb !== ws) o_viol++;
            w_wait++;
            if (w_wait > w_dly) begin wready = 1; w_pend = 1; end
         end
         // AR channel
         if (ar_pend) begin ar_done = 1; ar_pend = 0; if (arvalid) o_viol++; end
         else if (o_ar != 0 && !ar_done && !arvalid) o_viol++;
         arready = 0;
         if (arvalid) begin
            o_ar++;
            if (is_wr || ar_done || araddr !== addr || arprot !== 3'b000) o_viol++;
            ar_wait++;
            if (ar_wait > ar_dly) begin arready = 1; ar_pend = 1; end
         end
         // B / R channel
         if (rs_pend) begin rs_done = 1; rs_pend = 0; if (req_ready !== 1'b1) o_viol++; end
         else if (req_ready) o_viol++;
         rdy_now = is_wr ? bready : rready;
         if (is_wr ? rready : bready) o_viol++;
         if (rdy_now && !rsp_valid && !rsp_seen) o_rdy++;
         bvalid = 0; rvalid = 0;
         bresp = 2'($urandom()); rresp = 2'($urandom()); rdata = $urandom();
         if (rdy_now) begin
            if (rs_done || (is_wr ? !(aw_done && w_done) : !ar_done)) o_viol++;
            if (!rs_done) begin
               rs_wait++;
               if (rs_wait > resp_dly) begin
                  rs_pend = 1;
                  if (is_wr) begin bvalid = 1; bresp = resp; end
                  else begin rvalid = 1; rresp = resp; rdata = rd; end
               end
            end
         end
         // response port
         if (rsp_valid) begin
            o_n_rsp++;
            if (!rsp_seen) begin o_err = rsp_err; o_tmo = rsp_timeout; o_rdata = rsp_rdata; end
            rsp_seen = 1;
         end else if (rsp_err || rsp_timeout) begin
            o_viol++;
         end
         if (rs_done && rsp_seen) finished = 1;
         else @(negedge aclk);
      end
      if (!finished) o_hung = 1;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; req_valid = 0;
      repeat (3) begin
         @(negedge aclk);
         if (rsp_valid) o_n_rsp++;
         if (awvalid || wvalid || arvalid || bready || rready || req_ready !== 1'b1) o_viol++;
      end
   endtask

   task automatic test_reset();
      areset_n = 1;
      req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = '0; rresp = '0; rdata = '0;
      #2 areset_n = 0;
      repeat (2) @(negedge aclk);
      checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_timeout, awvalid, wvalid, bready, arvalid, rready} !== 9'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy/rsp/valids=%b, want 000000000",
                  {req_ready, rsp_valid, rsp_err, rsp_timeout, awvalid, wvalid, bready, arvalid, rready});
      end
      checks++;
      if ({rsp_rdata, awaddr, araddr, wdata, wstrb, awprot, arprot} !== '0) begin
         errors++;
         $display("FAIL reset_data: got rdata=%h awaddr=%h araddr=%h wdata=%h wstrb=%h, want all 0",
                  rsp_rdata, awaddr, araddr, wdata, wstrb);
      end
      areset_n = 1;
      @(negedge aclk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got req_ready=%b, want 1", req_ready);
      end
   endtask

   task automatic test_write_basic();
      logic [33:0] exp;
      predict(1, 0, 0, 0, 0, 2'b00, 32'h0);
      run_txn(1, 32'h10, 32'h12345678, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 0);
      exp = exp_q.pop_front();
      checks++;
      if ({o_tmo, o_err, o_rdata} !== exp) begin
         errors++;
         $display("FAIL write_basic rsp: got tmo=%0b err=%0b rdata=%h, want %h", o_tmo, o_err, o_rdata, exp);
      end
      checks++;
      if (o_n_rsp !== 1 || o_hung !== 1'b0 || o_rdy !== exp_rdy) begin
         errors++;
         $display("FAIL write_basic count: got rsp=%0d hung=%0b rdy=%0d, want 1 0 %0d", o_n_rsp, o_hung, o_rdy, exp_rdy);
      end
      checks++;
      if (o_viol !== 0 || o_aw !== exp_aw || o_w !== exp_w || o_ar !== exp_ar) begin
         errors++;
         $display("FAIL write_basic proto: got viol=%0d aw=%0d w=%0d ar=%0d, want 0 %0d %0d %0d", o_viol, o_aw, o_w, o_ar, exp_aw, exp_w, exp_ar);
      end
   endtask

   task automatic test_skewed_write();
      logic [33:0] exp;
      int aw_d[3] = '{3, 0, 1};
      int w_d[3]  = '{0, 2, 1};
      for (int i = 0; i < 3; i++) begin
         predict(1, aw_d[i], w_d[i], 0, 1, 2'b01, 32'h0);
         run_txn(1, 32'h100 + 32'(i * 4), $urandom(), 4'(i + 3), aw_d[i], w_d[i], 0, 1, 2'b01, 32'h0, 0);
         exp = exp_q.pop_front();
         checks++;
         if ({o_tmo, o_err, o_rdata} !== exp) begin
            errors++;
            $display("FAIL skew[%0d] rsp: got tmo=%0b err=%0b rdata=%h, want %h", i, o_tmo, o_err, o_rdata, exp);
         end
         checks++;
         if (o_n_rsp !== 1 || o_hung !== 1'b0 || o_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL skew[%0d] count: got rsp=%0d hung=%0b rdy=%0d, want 1 0 %0d", i, o_n_rsp, o_hung, o_rdy, exp_rdy);
         end
         checks++;
         if (o_viol !== 0 || o_aw !== exp_aw || o_w !== exp_w || o_ar !== exp_ar) begin
            errors++;
            $display("FAIL skew[%0d] proto: got viol=%0d aw=%0d w=%0d, want 0 %0d %0d", i, o_viol, o_aw, o_w, exp_aw, exp_w);
         end
      end
   endtask

   task automatic test_read_sticky();
      logic [33:0] exp;
      logic        wr;
      for (int i = 0; i < 2; i++) begin
         wr = (i == 1);
         predict(wr, 0, 0, 1, 2, 2'b00, 32'hDEADBEEF);
         run_txn(wr, 32'h20, 32'hCAFEF00D, 4'h3, 0, 0, 1, 2, 2'b00, 32'hDEADBEEF, 0);
         exp = exp_q.pop_front();
         checks++;
         if ({o_tmo, o_err, o_rdata} !== exp) begin
            errors++;
            $display("FAIL read_sticky[%0d] rsp: got tmo=%0b err=%0b rdata=%h, want %h", i, o_tmo, o_err, o_rdata, exp);
         end
         checks++;
         if (o_n_rsp !== 1 || o_hung !== 1'b0 || o_rdy !== exp_rdy || o_viol !== 0 || o_ar !== exp_ar) begin
            errors++;
            $display("FAIL read_sticky[%0d] flow: got rsp=%0d hung=%0b rdy=%0d viol=%0d ar=%0d, want 1 0 %0d 0 %0d",
                     i, o_n_rsp, o_hung, o_rdy, o_viol, o_ar, exp_rdy, exp_ar);
         end
      end
   endtask

   task automatic test_error_resp();
      logic [33:0] exp;
      logic        wr;
      logic [1:0]  rsp_code;
      for (int i = 0; i < 2; i++) begin
         wr = (i == 1);
         rsp_code = wr ? 2'b11 : 2'b10;
         predict(wr, 1, 0, 0, 0, rsp_code, 32'h0BAD0BAD);
         run_txn(wr, 32'h30, 32'h5, 4'h1, 1, 0, 0, 0, rsp_code, 32'h0BAD0BAD, 0);
         exp = exp_q.pop_front();
         checks++;
         if ({o_tmo, o_err, o_rdata} !== exp) begin
            errors++;
            $display("FAIL error_resp[%0d] rsp: got tmo=%0b err=%0b rdata=%h, want %h", i, o_tmo, o_err, o_rdata, exp);
         end
         checks++;
         if (o_n_rsp !== 1 || o_hung !== 1'b0 || o_rdy !== exp_rdy || o_viol !== 0) begin
            errors++;
            $display("FAIL error_resp[%0d] flow: got rsp=%0d hung=%0b rdy=%0d viol=%0d, want 1 0 %0d 0",
                     i, o_n_rsp, o_hung, o_rdy, o_viol, exp_rdy);
         end
      end
   endtask

   task automatic test_timeout();
      logic [33:0] exp;
      logic        wr_t[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      int          dly_t[4] = '{12, 7, 9, 8};
      for (int i = 0; i < 4; i++) begin
         predict(wr_t[i], 0, 0, 0, dly_t[i], 2'b00, 32'h600D0000 + 32'(i));
         run_txn(wr_t[i], 32'h40, $urandom(), 4'hF, 0, 0, 0, dly_t[i], 2'b00, 32'h600D0000 + 32'(i), 0);
         exp = exp_q.pop_front();
         checks++;
         if ({o_tmo, o_err, o_rdata} !== exp) begin
            errors++;
            $display("FAIL timeout[%0d] rsp: got tmo=%0b err=%0b rdata=%h, want %h", i, o_tmo, o_err, o_rdata, exp);
         end
         checks++;
         if (o_n_rsp !== 1 || o_hung !== 1'b0 || o_rdy !== exp_rdy) begin
            errors++;
            $display("FAIL timeout[%0d] count: got rsp=%0d hung=%0b rdy=%0d, want 1 0 %0d", i, o_n_rsp, o_hung, o_rdy, exp_rdy);
         end
         checks++;
         if (o_viol !== 0) begin
            errors++;
            $display("FAIL timeout[%0d] proto: got viol=%0d, want 0", i, o_viol);
         end
      end
   endtask

   task automatic test_busy();
      logic [33:0] exp;
      predict(0, 0, 0, 2, 0, 2'b00, 32'h13579BDF);
      run_txn(0, 32'h50, 32'h0, 4'h0, 0, 0, 2, 0, 2'b00, 32'h13579BDF, 1);
      exp = exp_q.pop_front();
      checks++;
      if ({o_tmo, o_err, o_rdata} !== exp) begin
         errors++;
         $display("FAIL busy rsp: got tmo=%0b err=%0b rdata=%h, want %h", o_tmo, o_err, o_rdata, exp);
      end
      checks++;
      if (o_n_rsp !== 1 || o_hung !== 1'b0 || o_viol !== 0 || o_aw !== 0 || o_ar !== exp_ar) begin
         errors++;
         $display("FAIL busy flow: got rsp=%0d hung=%0b viol=%0d aw=%0d ar=%0d, want 1 0 0 0 %0d",
                  o_n_rsp, o_hung, o_viol, o_aw, o_ar, exp_ar);
      end
   endtask

   task automatic test_random();
      logic [33:0] exp;
      logic        wr;
      logic [1:0]  rc;
      int          ad, wd_, rdl, dl;
      logic [31:0] rdv;
      for (int i = 0; i < 30; i++) begin
         wr  = 1'($urandom_range(0, 1));
         ad  = $urandom_range(0, 3);
         wd_ = $urandom_range(0, 3);
         rdl = $urandom_range(0, 3);
         dl  = ($urandom_range(0, 4) == 0) ? $urandom_range(7, 11) : $urandom_range(0, 4);
         rc  = 2'($urandom_range(0, 3));
         rdv = $urandom();
         predict(wr, ad, wd_, rdl, dl, rc, rdv);
         run_txn(wr, $urandom(), $urandom(), 4'($urandom()), ad, wd_, rdl, dl, rc, rdv,
                 1'($urandom_range(0, 1)));
         exp = exp_q.pop_front();
         checks++;
         if ({o_tmo, o_err, o_rdata} !== exp) begin
            errors++;
            $display("FAIL random[%0d] rsp: got tmo=%0b err=%0b rdata=%h, want %h", i, o_tmo, o_err, o_rdata, exp);
         end
         checks++;
         if (o_n_rsp !== 1 || o_hung !== 1'b0 || o_rdy !== exp_rdy || o_viol !== 0 ||
             o_aw !== exp_aw || o_w !== exp_w || o_ar !== exp_ar) begin
            errors++;
            $display("FAIL random[%0d] flow: got rsp=%0d hung=%0b rdy=%0d viol=%0d aw=%0d w=%0d ar=%0d, want 1 0 %0d 0 %0d %0d %0d",
                     i, o_n_rsp, o_hung, o_rdy, o_viol, o_aw, o_w, o_ar, exp_rdy, exp_aw, exp_w, exp_ar);
         end
      end
   endtask

   task automatic test_reset_midflight();
      @(negedge aclk);
      req_valid = 1; req_write = 0; req_addr = 32'h40; arready = 0;
      @(negedge aclk);
      req_valid = 0;
      @(negedge aclk);
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h40) begin
         errors++;
         $display("FAIL midflight_ar: got arvalid=%b araddr=%h, want 1 00000040", arvalid, araddr);
      end
      #2 areset_n = 0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, rsp_timeout, awvalid, wvalid, bready, arvalid, rready} !== 9'b0) begin
         errors++;
         $display("FAIL midflight_ctrl: got rdy/rsp/valids=%b, want 000000000",
                  {req_ready, rsp_valid, rsp_err, rsp_timeout, awvalid, wvalid, bready, arvalid, rready});
      end
      checks++;
      if ({rsp_rdata, awaddr, araddr, wdata, wstrb} !== '0) begin
         errors++;
         $display("FAIL midflight_data: got rdata=%h awaddr=%h araddr=%h wdata=%h wstrb=%h, want all 0",
                  rsp_rdata, awaddr, araddr, wdata, wstrb);
      end
      repeat (2) @(negedge aclk);
      areset_n = 1;
      last_rdata = '0;
      @(negedge aclk);
      checks++;
      if (req_ready !== 1'b1 || arvalid !== 1'b0) begin
         errors++;
         $display("FAIL midflight_release: got req_ready=%b arvalid=%b, want 1 0", req_ready, arvalid);
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_skewed_write();
      test_read_sticky();
      test_error_resp();
      test_timeout();
      test_busy();
      test_random();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi4lite_master.md
Name: axi4lite_master

Overview:
- AXI4-Lite manager (initiator) that drives register blocks such as the generated AXI4-Lite register banks.
- Accepts single read/write commands on a simple valid/ready request port and runs one AXI4-Lite transaction at a time.
- Returns data and status on a one-cycle response strobe.
- Response-phase timeout protects the host side against a hung subordinate.

Parameters:
- ADDR_WIDTH, 32: width of req_addr, awaddr and araddr.
- TIMEOUT, 255: cycles to wait for bvalid/rvalid after the address/data handshakes complete. 0 disables the timeout.

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high together with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  write byte strobes
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  read data
- rsp_err  out  1  bresp/rresp[1] was set (SLVERR or DECERR)
- rsp_timeout  out  1  response timed out
- awvalid, awready, awaddr[ADDR_WIDTH], awprot[3]  out/in/out/out  AXI write-address channel
- wvalid, wready, wdata[32], wstrb[4]  out/in/out/out  AXI write-data channel
- bvalid, bready, bresp[2]  in/out/in  AXI write-response channel
- arvalid, arready, araddr[ADDR_WIDTH], arprot[3]  out/in/out/out  AXI read-address channel
- rvalid, rready, rdata[32], rresp[2]  in/out/in/in  AXI read-data channel

Behaviour:
- Reset (async, areset_n low):
  - FSM goes to IDLE.
  - All valid, ready and rsp_* outputs are 0; rsp_rdata, awaddr, araddr, wdata and wstrb are 0.
  - An in-flight transaction is abandoned.
- awprot and arprot are constant 3'b000.
- FSM states: IDLE, WRITE, WRESP, READ, RRESP, FLUSH.
- IDLE:
  - req_ready = 1; it is 0 in every other state.
  - On req_valid, the command is captured in the same cycle and the FSM moves to WRITE or READ according to req_write.
- WRITE:
  - awvalid and wvalid both rise in the cycle after acceptance.
  - Each drops independently in the cycle after its own ready was sampled high; AW and W may complete in either order or together.
  - awaddr, wdata and wstrb stay stable while their valid is high.
  - The FSM moves to WRESP in the cycle after both handshakes are done.
- WRESP:
  - bready = 1.
  - On bvalid: next cycle rsp_valid = 1, rsp_err = bresp[1], rsp_timeout = 0, and the FSM returns to IDLE (req_ready = 1 in that same cycle).
- READ:
  - arvalid rises in the cycle after acceptance and drops in the cycle after arready is sampled high; the FSM then moves to RRESP.
- RRESP:
  - rready = 1.
  - On rvalid: rsp_rdata <= rdata and rsp_err <= rresp[1]; next cycle rsp_valid = 1, then IDLE.
- Response output rules:
  - rsp_rdata holds its value until the next completed read.
  - A write response drives rsp_rdata unchanged.
  - rsp_valid has no backpressure; it is high for exactly one cycle per command.
- Timeout (TIMEOUT > 0):
  - A counter clears on entry to WRESP or RRESP and increments each cycle without bvalid/rvalid.
  - When it reaches TIMEOUT:
    - the next cycle gives rsp_valid = 1, rsp_timeout = 1 and rsp_err = 1;
    - the FSM moves to FLUSH.
- FLUSH:
  - bready or rready (whichever matches the pending direction) stays 1 and req_ready = 0.
  - The late response is consumed and discarded, then the FSM returns to IDLE.
  - No second rsp_valid is produced.
- Address/data phases never time out. Valids are never withdrawn before their handshake, as AXI requires.
- req_valid while busy is ignored; the command is not captured.
- Only one outstanding transaction exists at any time.

Test Plan:
- Write with always-ready subordinate:
  - Stimulus: req addr 0x10, data 0x12345678, wstrb 0xF.
  - Required: awvalid and wvalid high one cycle; bvalid with OKAY.
  - Required: rsp_valid one cycle later with rsp_err = 0 and rsp_timeout = 0.
- Skewed write:
  - Stimulus: wready asserted 3 cycles before awready.
  - Required: wvalid drops after its handshake while awvalid stays high with a stable awaddr; bready rises only after the AW handshake; one rsp_valid.
- Read:
  - Stimulus: subordinate returns rdata 0xDEADBEEF with rresp 2'b00.
  - Required: rsp_rdata = 0xDEADBEEF and rsp_err = 0.
  - Required: a following write leaves rsp_rdata = 0xDEADBEEF.
- Error response:
  - Stimulus: a read answered with SLVERR, then a write answered with DECERR.
  - Required: rsp_err = 1 on both responses.
- Timeout, TIMEOUT = 8:
  - Stimulus: bvalid withheld.
  - Required: rsp_valid with rsp_timeout = 1 in the cycle after 8 cycles of bready high.
  - Stimulus: bvalid arrives 5 cycles later.
  - Required: bvalid is consumed with no further rsp_valid, and req_ready is 1 the cycle after.
- Busy and reset:
  - Stimulus: req_valid pulsed during READ.
  - Required: the pulse is ignored.
  - Stimulus: areset_n asserted while arvalid is high.
  - Required: all valids and rsp_* are 0 immediately; req_ready = 1 after release.
